// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit add/subtract unit, one carry chunk per stage, valid/ready on both sides.
// Define ADDER_PIPE_SAT_EN to build signed saturation (requested per beat by Sat).

module adder_1bit #(
    parameter int unsigned IMPL_TYPE = 0
) (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum_c,
    output logic cout_c
);
    if (IMPL_TYPE == 0) begin : g_xor
        assign sum_c  = a ^ b ^ ci;
        assign cout_c = (a & b) | (ci & (a ^ b));
    end else begin : g_mux
        // Propagate-select form: carry passes through when a != b, else a generates/kills it.
        logic p;
        assign p      = a ^ b;
        assign sum_c  = p ? ~ci : ci;
        assign cout_c = p ? ci : a;
    end
endmodule

module adder_pipe_nbit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned STAGES    = 4,
    parameter int unsigned IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    input  logic             Sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);
    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

`ifdef ADDER_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [STAGES-1:0]             valid_q, valid_d, carry_q, carry_d;
    logic [STAGES-1:0]             ovf_q, ovf_d, sat_q, sat_d;
    logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;

    logic [STAGES-1:0][WIDTH-1:0]  a_in, b_in, sum_in;
    logic [STAGES-1:0]             c_in, v_in, sat_in;
    logic [STAGES-1:0][CHUNK-1:0]  s_chunk;
    logic [STAGES-1:0]             co_chunk, cm_chunk;
    logic                          stall_c;

    assign stall_c  = valid_q[LAST] & ~out_ready;
    assign in_ready = ~stall_c;

    // Stage k consumes the port beat (k=0) or the register bank of stage k-1.
    always_comb begin : stage_inputs
        a_in      = '0;
        b_in      = '0;
        sum_in    = '0;
        c_in      = '0;
        v_in      = '0;
        sat_in    = '0;
        a_in[0]   = A;
        b_in[0]   = Sub ? ~B : B;
        c_in[0]   = Cin ^ Sub;
        v_in[0]   = in_valid;
        sat_in[0] = Sat;
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            sum_in[k] = sum_q[k-1];
            c_in[k]   = carry_q[k-1];
            v_in[k]   = valid_q[k-1];
            sat_in[k] = sat_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        for (genvar i = 0; i < CHUNK; i++) begin : g_bit
            logic ci, co;
            if (i == 0) begin : g_c0
                assign ci = c_in[k];
            end else begin : g_cn
                assign ci = g_bit[i-1].co;
            end
            adder_1bit #(.IMPL_TYPE(IMPL_TYPE)) u_cell (
                .a      (a_in[k][k*CHUNK+i]),
                .b      (b_in[k][k*CHUNK+i]),
                .ci     (ci),
                .sum_c  (s_chunk[k][i]),
                .cout_c (co)
            );
        end
        assign co_chunk[k] = g_bit[CHUNK-1].co;
        assign cm_chunk[k] = g_bit[CHUNK-1].ci;
    end

    // Each stage fills its own result chunk; only the last stage's Ovf/Sat matter.
    always_comb begin : stage_next
        valid_d = v_in;
        carry_d = co_chunk;
        ovf_d   = co_chunk ^ cm_chunk;
        sat_d   = sat_in;
        a_d     = a_in;
        b_d     = b_in;
        sum_d   = sum_in;
        for (int unsigned k = 0; k < STAGES; k++) begin
            sum_d[k][k*CHUNK +: CHUNK] = s_chunk[k];
        end
`ifdef ADDER_PIPE_SAT_EN
        if (sat_in[LAST] && ovf_d[LAST]) begin
            sum_d[LAST] = a_in[LAST][WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
`endif
    end

    // Global stall: every stage holds while the output beat waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= '0;
            sat_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else if (!stall_c) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            sat_q   <= sat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign Sum       = sum_q[LAST];
    assign Cout      = carry_q[LAST];
    assign Ovf       = ovf_q[LAST];

    // Operand skew of the last stage and early-stage overflow bits have no consumer.
    logic unused_ok;
    assign unused_ok = ^{a_q[LAST], b_q[LAST], ovf_q, sat_q[LAST]};

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit: four instances (STAGES 4,1,2,8) checked against an arithmetic model.
module tb_adder_pipe_nbit;
`ifdef ADDER_PIPE_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif
    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_v, out_ready_v;
    logic [31:0] a_v, b_v;
    logic        cin_v, sub_v, sat_v;

    logic        in_ready_w  [ND];
    logic        out_valid_w [ND];
    logic [31:0] sum_w       [ND];
    logic        cout_w      [ND];
    logic        ovf_w       [ND];

    int          tests = 0;
    int          fails = 0;
    logic [33:0] exp_mem  [ND][256];
    int unsigned wr       [ND];
    int unsigned rd       [ND];
    logic        held     [ND];
    logic [33:0] held_val [ND];
    logic        last_acc0;
    int          idx;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int unsigned STG = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 8;
        localparam int unsigned IMP = (g == 1 || g == 3) ? 1 : 0;
        adder_pipe_nbit #(.WIDTH(32), .STAGES(STG), .IMPL_TYPE(IMP)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_v),
            .in_ready  (in_ready_w[g]),
            .A         (a_v),
            .B         (b_v),
            .Cin       (cin_v),
            .Sub       (sub_v),
            .Sat       (sat_v),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready_v),
            .Sum       (sum_w[g]),
            .Cout      (cout_w[g]),
            .Ovf       (ovf_w[g])
        );
    end

    // Reference: {Cout, Ovf, Sum} from plain 33-bit arithmetic.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub, input logic sat);
        logic [31:0] be;
        logic [32:0] full;
        logic [31:0] s;
        logic        ovf;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + 33'(cin ^ sub);
        s    = full[31:0];
        ovf  = (a[31] == be[31]) && (s[31] != a[31]);
        if (sat && SAT_BUILD && ovf) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return {full[32], ovf, s};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic check1(input string name, input int d, input logic [33:0] got, input logic [33:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s dut%0d got=%h exp=%h", name, d, got, expv);
        end
    endtask

    // Per-cycle scoreboard, sampled at the falling edge.
    task automatic score();
        logic [33:0] got;
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) begin
                wr[d] = 0; rd[d] = 0; held[d] = 1'b0;
            end
            last_acc0 = 1'b0;
            return;
        end
        last_acc0 = in_valid_v && in_ready_w[0];
        for (int d = 0; d < ND; d++) begin
            got = {cout_w[d], ovf_w[d], sum_w[d]};
            check1("in_ready", d, 34'(in_ready_w[d]), 34'(!(out_valid_w[d] && !out_ready_v)));
            if (held[d]) begin
                check1("hold_valid", d, 34'(out_valid_w[d]), 34'(1));
                check1("hold_data", d, got, held_val[d]);
            end
            if (out_valid_w[d]) begin
                if (rd[d] == wr[d]) begin
                    tests++; fails++;
                    $display("FAIL extra_beat dut%0d got=%h exp=none", d, got);
                end else begin
                    check1("result", d, got, exp_mem[d][rd[d] % 256]);
                    if (out_ready_v) rd[d]++;
                end
                held[d]     = !out_ready_v;
                held_val[d] = got;
            end else begin
                held[d] = 1'b0;
            end
            if (in_valid_v && in_ready_w[d]) begin
                exp_mem[d][wr[d] % 256] = model(a_v, b_v, cin_v, sub_v, sat_v);
                wr[d]++;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        score();
        @(posedge clk);
        #1;
    endtask

    // One beat into an empty pipe; pins latency 4 and a literal result on dut0.
    task automatic send_dir(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input logic sub, input logic sat, input logic [33:0] expv);
        a_v = a; b_v = b; cin_v = cin; sub_v = sub; sat_v = sat;
        in_valid_v = 1'b1; out_ready_v = 1'b1;
        tick();
        in_valid_v = 1'b0;
        tick();
        tick();
        check1({name, "_early"}, 0, 34'(out_valid_w[0]), 34'(0));
        tick();
        check1({name, "_valid"}, 0, 34'(out_valid_w[0]), 34'(1));
        check1(name, 0, {cout_w[0], ovf_w[0], sum_w[0]}, expv);
        repeat (10) tick();
    endtask

    task automatic drain_and_count(input string name);
        in_valid_v = 1'b0; out_ready_v = 1'b1;
        repeat (14) tick();
        for (int d = 0; d < ND; d++) check1(name, d, 34'(wr[d]), 34'(rd[d]));
    endtask

    initial begin
        rst_n = 1'b0; in_valid_v = 1'b0; out_ready_v = 1'b1;
        a_v = '0; b_v = '0; cin_v = 1'b0; sub_v = 1'b0; sat_v = 1'b0;
        for (int d = 0; d < ND; d++) begin
            wr[d] = 0; rd[d] = 0; held[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check1("rst_out_valid", d, 34'(out_valid_w[d]), 34'(0));
            check1("rst_result", d, {cout_w[d], ovf_w[d], sum_w[d]}, 34'(0));
            check1("rst_in_ready", d, 34'(in_ready_w[d]), 34'(1));
        end
        rst_n = 1'b1;
        tick(); tick();

        send_dir("carry_all", 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, {1'b1, 1'b0, 32'h0000_0000});
        send_dir("sub_5_7",   32'd5, 32'd7, 1'b0, 1'b1, 1'b0, {1'b0, 1'b0, 32'hFFFF_FFFE});
        send_dir("sub_7_5",   32'd7, 32'd5, 1'b0, 1'b1, 1'b0, {1'b1, 1'b0, 32'h0000_0002});
        send_dir("sub_borrow", 32'd7, 32'd5, 1'b1, 1'b1, 1'b0, {1'b1, 1'b0, 32'h0000_0001});
        send_dir("ovf_sat",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1,
                 {1'b0, 1'b1, (SAT_BUILD ? 32'h7FFF_FFFF : 32'h8000_0000)});
        send_dir("neg_sat",   32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1,
                 {1'b1, 1'b1, (SAT_BUILD ? 32'h8000_0000 : 32'h7FFF_FFFF)});

        // Asynchronous reset with beats in flight.
        in_valid_v = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_v = $urandom; b_v = $urandom; tick();
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check1("rst_mid_valid", d, 34'(out_valid_w[d]), 34'(0));
            check1("rst_mid_sum", d, 34'(sum_w[d]), 34'(0));
        end
        in_valid_v = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        repeat (12) tick();
        drain_and_count("rst_count");

        // Ten back-to-back beats with out_ready low for stream cycles 6..8.
        idx = 0;
        for (int c = 0; c < 40 && idx < 10; c++) begin
            a_v = 32'(idx * 1000 + 17); b_v = 32'(idx * 3);
            cin_v = idx[0]; sub_v = idx[1]; sat_v = 1'b0;
            in_valid_v = 1'b1;
            out_ready_v = !(c >= 6 && c <= 8);
            tick();
            if (last_acc0) idx++;
        end
        check1("stream_accepted", 0, 34'(idx), 34'(10));
        drain_and_count("stream_count");

        // Random operands and handshake.
        for (int c = 0; c < 600; c++) begin
            a_v = pick(); b_v = pick();
            cin_v = 1'($urandom_range(0, 1)); sub_v = 1'($urandom_range(0, 1));
            sat_v = 1'($urandom_range(0, 1));
            in_valid_v  = ($urandom_range(0, 3) != 0);
            out_ready_v = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain_and_count("rand_count");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
